// File: rtl/keypad_entry_sequencer.sv
// keypad_entry_sequencer
//   Front end for the six-digit lock controller. Collects key strokes into a
//   six-digit buffer and, on ENTER, replays it as three pair-writes. In entry
//   mode it then presents the judge select, waits JUDGE_WAIT cycles, and
//   samples lk_res to produce an unlock or fail pulse.
//
//   Optional feature macro: FAIL_LOCKOUT_EN
//     defined   : consecutive failures are counted; reaching MAX_FAIL enters a
//                 LOCKOUT period of LOCKOUT_CYCLES cycles with lockout high.
//     undefined : no counter, no LOCKOUT; a failure simply returns to IDLE and
//                 lockout is tied low.
//
//   Ports
//     clk        system clock, rising edge
//     clr_n      asynchronous active-low reset
//     key_valid  one-cycle key strobe (no ready: the sequencer never stalls the
//                keypad; strokes arriving outside IDLE are dropped)
//     key_code   0-9 digit, A ENTER, B BACKSPACE, C CANCEL, D-F ignored
//     mode_req   0 set password, 1 enter password (taken while buffer empty)
//     lk_res     compare result from the lock controller
//     lk_m       mode to the lock controller
//     lk_inA/B   digit pair being written
//     lk_a0/a1   position select {a1,a0}: 00/01/10 pair 1/2/3, 11 judge/idle
//     lk_clr     one-cycle clear toward the lock controller (CANCEL)
//     digit_cnt  digits buffered (0..6)
//     set_done   one-cycle pulse after a set-mode write
//     unlock     one-cycle pulse on a matching entry
//     fail       one-cycle pulse on a mismatching entry
//     lockout    high while locked out
module keypad_entry_sequencer #(
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int JUDGE_WAIT     = 2
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       mode_req,
  input  logic       lk_res,
  output logic       lk_m,
  output logic [3:0] lk_inA,
  output logic [3:0] lk_inB,
  output logic       lk_a0,
  output logic       lk_a1,
  output logic       lk_clr,
  output logic [2:0] digit_cnt,
  output logic       set_done,
  output logic       unlock,
  output logic       fail,
  output logic       lockout
);

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_BACK   = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  localparam int JW_W = (JUDGE_WAIT > 1) ? $clog2(JUDGE_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE1,
    S_WRITE2,
    S_WRITE3,
    S_JUDGE,
    S_LOCKOUT
  } state_t;

  state_t          state;
  logic [3:0]      digits [6];
  logic [1:0]      sel;
  logic [JW_W-1:0] judge_cnt;

  assign lk_a1 = sel[1];
  assign lk_a0 = sel[0];

`ifdef FAIL_LOCKOUT_EN
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  logic [3:0]    fail_cnt;
  logic [3:0]    fail_next;
  logic [LW-1:0] lock_cnt;
  logic          lockout_q;

  // Saturating increment so a large MAX_FAIL cannot wrap the counter.
  assign fail_next = (fail_cnt == 4'hF) ? fail_cnt : fail_cnt + 4'd1;
  assign lockout   = lockout_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{MAX_FAIL, LOCKOUT_CYCLES};
  assign lockout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= S_IDLE;
      lk_m      <= 1'b0;
      lk_inA    <= '0;
      lk_inB    <= '0;
      sel       <= 2'b11;
      lk_clr    <= 1'b0;
      digit_cnt <= '0;
      set_done  <= 1'b0;
      unlock    <= 1'b0;
      fail      <= 1'b0;
      judge_cnt <= '0;
      for (int i = 0; i < 6; i++) digits[i] <= '0;
`ifdef FAIL_LOCKOUT_EN
      fail_cnt  <= '0;
      lock_cnt  <= '0;
      lockout_q <= 1'b0;
`endif
    end else begin
      // Pulses default low; each is raised for exactly one cycle below.
      lk_clr   <= 1'b0;
      set_done <= 1'b0;
      unlock   <= 1'b0;
      fail     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (digit_cnt == 3'd0) lk_m <= mode_req;
          if (key_valid) begin
            if (key_code <= 4'd9) begin
              if (digit_cnt < 3'd6) begin
                digits[digit_cnt] <= key_code;
                digit_cnt         <= digit_cnt + 3'd1;
              end
            end else begin
              case (key_code)
                KEY_ENTER: begin
                  if (digit_cnt == 3'd6) begin
                    state  <= S_WRITE1;
                    sel    <= 2'b00;
                    lk_inA <= digits[0];
                    lk_inB <= digits[1];
                  end
                end
                KEY_BACK: begin
                  if (digit_cnt != 3'd0) digit_cnt <= digit_cnt - 3'd1;
                end
                KEY_CANCEL: begin
                  digit_cnt <= '0;
                  lk_clr    <= 1'b1;
                  for (int i = 0; i < 6; i++) digits[i] <= '0;
                end
                default: ;
              endcase
            end
          end
        end
        S_WRITE1: begin
          state  <= S_WRITE2;
          sel    <= 2'b01;
          lk_inA <= digits[2];
          lk_inB <= digits[3];
        end
        S_WRITE2: begin
          state  <= S_WRITE3;
          sel    <= 2'b10;
          lk_inA <= digits[4];
          lk_inB <= digits[5];
        end
        S_WRITE3: begin
          sel    <= 2'b11;
          lk_inA <= '0;
          lk_inB <= '0;
          if (!lk_m) begin
            set_done  <= 1'b1;
            state     <= S_IDLE;
            digit_cnt <= '0;
            for (int i = 0; i < 6; i++) digits[i] <= '0;
          end else begin
            state     <= S_JUDGE;
            judge_cnt <= '0;
          end
        end
        S_JUDGE: begin
          if (judge_cnt == JW_W'(JUDGE_WAIT - 1)) begin
            digit_cnt <= '0;
            for (int i = 0; i < 6; i++) digits[i] <= '0;
            if (lk_res) begin
              unlock <= 1'b1;
              state  <= S_IDLE;
`ifdef FAIL_LOCKOUT_EN
              fail_cnt <= '0;
`endif
            end else begin
              fail <= 1'b1;
`ifdef FAIL_LOCKOUT_EN
              fail_cnt <= fail_next;
              if (fail_next >= 4'(MAX_FAIL)) begin
                state     <= S_LOCKOUT;
                lockout_q <= 1'b1;
                lock_cnt  <= '0;
              end else begin
                state <= S_IDLE;
              end
`else
              state <= S_IDLE;
`endif
            end
          end else begin
            judge_cnt <= judge_cnt + JW_W'(1);
          end
        end
`ifdef FAIL_LOCKOUT_EN
        S_LOCKOUT: begin
          if (lock_cnt == LW'(LOCKOUT_CYCLES - 1)) begin
            lockout_q <= 1'b0;
            fail_cnt  <= '0;
            state     <= S_IDLE;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry_sequencer.sv
// tb_keypad_entry_sequencer
//   Directed scenarios plus randomized key traffic for keypad_entry_sequencer.
//   A timeline model (digit queue, ENTER timestamp, lockout window) predicts
//   every output for every cycle; a negedge process compares all outputs.
module tb_keypad_entry_sequencer;

  localparam int JW = 2;
  localparam int MF = 3;
  localparam int LC = 1000;
`ifdef FAIL_LOCKOUT_EN
  localparam int EXP_LOCK_LEN = LC;
`else
  localparam int EXP_LOCK_LEN = 0;
`endif

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       mode_req = 1'b0;
  logic       lk_res = 1'b0;
  logic       lk_m;
  logic [3:0] lk_inA;
  logic [3:0] lk_inB;
  logic       lk_a0;
  logic       lk_a1;
  logic       lk_clr;
  logic [2:0] digit_cnt;
  logic       set_done;
  logic       unlock;
  logic       fail;
  logic       lockout;

  keypad_entry_sequencer #(
    .MAX_FAIL(MF),
    .LOCKOUT_CYCLES(LC),
    .JUDGE_WAIT(JW)
  ) dut (
    .clk(clk),
    .clr_n(clr_n),
    .key_valid(key_valid),
    .key_code(key_code),
    .mode_req(mode_req),
    .lk_res(lk_res),
    .lk_m(lk_m),
    .lk_inA(lk_inA),
    .lk_inB(lk_inB),
    .lk_a0(lk_a0),
    .lk_a1(lk_a1),
    .lk_clr(lk_clr),
    .digit_cnt(digit_cnt),
    .set_done(set_done),
    .unlock(unlock),
    .fail(fail),
    .lockout(lockout)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds the buffered digits; an accepted ENTER is recorded as a
  // timestamp, and every later output is a function of the cycle offset.
  logic [3:0] exp_q[$];
  logic [3:0] op_d [6];
  logic       m_mode;
  int         m_fails;
  int         cyc;
  int         op_start;
  bit         op_judge;
  int         lock_begin;
  int         lock_end;
  int         k;
  int         n;
  bit         idle_now;

  logic       e_lk_m;
  logic [1:0] e_sel;
  logic [3:0] e_in_a;
  logic [3:0] e_in_b;
  logic       e_clr;
  logic [2:0] e_cnt;
  logic       e_set_done;
  logic       e_unlock;
  logic       e_fail;
  logic       e_lockout;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      exp_q.delete();
      m_mode = 1'b0; m_fails = 0; op_start = -1; op_judge = 1'b0;
      lock_begin = 0; lock_end = 0;
      e_lk_m = 1'b0; e_sel = 2'b11; e_in_a = 4'h0; e_in_b = 4'h0; e_clr = 1'b0;
      e_cnt = 3'd0; e_set_done = 1'b0; e_unlock = 1'b0; e_fail = 1'b0; e_lockout = 1'b0;
    end else begin
      n = cyc + 1;
      e_sel = 2'b11; e_in_a = 4'h0; e_in_b = 4'h0; e_clr = 1'b0;
      e_set_done = 1'b0; e_unlock = 1'b0; e_fail = 1'b0;
      idle_now = (op_start < 0) && (cyc >= lock_end);
      if (idle_now) begin
        if (exp_q.size() == 0) m_mode = mode_req;
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (exp_q.size() < 6) exp_q.push_back(key_code);
          end else if (key_code == 4'hA) begin
            if (exp_q.size() == 6) begin
              op_start = cyc;
              op_judge = m_mode;
              for (int i = 0; i < 6; i++) op_d[i] = exp_q[i];
            end
          end else if (key_code == 4'hB) begin
            if (exp_q.size() > 0) void'(exp_q.pop_back());
          end else if (key_code == 4'hC) begin
            exp_q.delete();
            e_clr = 1'b1;
          end
        end
      end
      if (op_start >= 0) begin
        k = n - op_start;
        if (k >= 1 && k <= 3) begin
          e_sel  = 2'(k - 1);
          e_in_a = op_d[2*(k-1)];
          e_in_b = op_d[2*k-1];
        end else if (!op_judge && k == 4) begin
          e_set_done = 1'b1;
          op_start = -1;
          exp_q.delete();
        end else if (op_judge && k == 4 + JW) begin
          if (lk_res) begin
            e_unlock = 1'b1;
            m_fails = 0;
          end else begin
            e_fail = 1'b1;
            m_fails = (m_fails < 15) ? m_fails + 1 : 15;
`ifdef FAIL_LOCKOUT_EN
            if (m_fails >= MF) begin
              lock_begin = n;
              lock_end = n + LC;
              m_fails = 0;
            end
`endif
          end
          op_start = -1;
          exp_q.delete();
        end
      end
      e_cnt = 3'(exp_q.size());
      e_lk_m = m_mode;
      e_lockout = (n >= lock_begin) && (n < lock_end);
      cyc++;
    end
  end

  initial cyc = 0;

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("lk_m", lk_m, e_lk_m);
    chk("sel", {lk_a1, lk_a0}, e_sel);
    chk("lk_inA", lk_inA, e_in_a);
    chk("lk_inB", lk_inB, e_in_b);
    chk("lk_clr", lk_clr, e_clr);
    chk("digit_cnt", digit_cnt, e_cnt);
    chk("set_done", set_done, e_set_done);
    chk("unlock", unlock, e_unlock);
    chk("fail", fail, e_fail);
    chk("lockout", lockout, e_lockout);
  end

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----
  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code = code;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic type_digits(input logic [3:0] d0, d1, d2, d3, d4, d5);
    press(d0); press(d1); press(d2); press(d3); press(d4); press(d5);
  endtask

  // Press ENTER and count cycles until an unlock/fail pulse (bounded).
  task automatic enter_and_wait(output int lat, output logic got_unlock, output logic got_fail);
    key_valid = 1'b1;
    key_code = 4'hA;
    lat = 0;
    do begin
      @(negedge clk);
      key_valid = 1'b0;
      lat++;
    end while (!(unlock || fail) && lat < 40);
    got_unlock = unlock;
    got_fail = fail;
  endtask

  task automatic random_key();
    int r;
    key_valid = ($urandom_range(0, 99) < 60);
    r = $urandom_range(0, 99);
    if (r < 70)      key_code = 4'($urandom_range(0, 9));
    else if (r < 80) key_code = 4'hA;
    else if (r < 87) key_code = 4'hB;
    else if (r < 91) key_code = 4'hC;
    else             key_code = 4'($urandom_range(13, 15));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int cnt;
    logic gu;
    logic gf;

    repeat (3) @(negedge clk);
    chk("rst_sel", {lk_a1, lk_a0}, 2'b11);
    chk("rst_cnt", digit_cnt, 3'd0);
    chk("rst_lockout", lockout, 1'b0);
    clr_n = 1'b1;
    @(negedge clk);

    // Set mode: 1..6 ENTER, pairs written one cycle each.
    mode_req = 1'b0;
    type_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    press(4'hA);
    chk("set_w1_sel", {lk_a1, lk_a0}, 2'b00);
    chk("set_w1_a", lk_inA, 4'd1);
    chk("set_w1_b", lk_inB, 4'd2);
    @(negedge clk);
    chk("set_w2_sel", {lk_a1, lk_a0}, 2'b01);
    chk("set_w2_a", lk_inA, 4'd3);
    @(negedge clk);
    chk("set_w3_sel", {lk_a1, lk_a0}, 2'b10);
    chk("set_w3_b", lk_inB, 4'd6);
    @(negedge clk);
    chk("set_done_pulse", set_done, 1'b1);
    chk("set_cnt_clr", digit_cnt, 3'd0);
    @(negedge clk);

    // Entry mode, match: unlock after 3+JUDGE_WAIT+1 cycles.
    mode_req = 1'b1;
    lk_res = 1'b1;
    type_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    enter_and_wait(lat, gu, gf);
    chk("unlock_latency", lat, 3 + JW + 1);
    chk("unlock_seen", gu, 1'b1);
    chk("no_fail", gf, 1'b0);
    @(negedge clk);

    // Backspace edit, then a seventh digit is dropped.
    mode_req = 1'b0;
    press(4'd1); press(4'd2); press(4'd3); press(4'hB);
    chk("bs_cnt", digit_cnt, 3'd2);
    press(4'd9); press(4'd4); press(4'd5); press(4'd6);
    press(4'd7);
    chk("full_cnt", digit_cnt, 3'd6);
    press(4'hA);
    chk("bs_w1_a", lk_inA, 4'd1);
    chk("bs_w1_b", lk_inB, 4'd2);
    @(negedge clk);
    chk("bs_w2_a", lk_inA, 4'd9);
    chk("bs_w2_b", lk_inB, 4'd4);
    @(negedge clk);
    chk("bs_w3_a", lk_inA, 4'd5);
    chk("bs_w3_b", lk_inB, 4'd6);
    repeat (2) @(negedge clk);

    // Short ENTER ignored; CANCEL clears and pulses lk_clr.
    type_digits(4'd8, 4'd8, 4'd8, 4'd8, 4'd0, 4'd0);
    press(4'hB); press(4'hB);
    press(4'hA);
    chk("short_enter_sel", {lk_a1, lk_a0}, 2'b11);
    chk("short_enter_cnt", digit_cnt, 3'd4);
    press(4'hC);
    chk("cancel_clr", lk_clr, 1'b1);
    chk("cancel_cnt", digit_cnt, 3'd0);
    @(negedge clk);
    chk("cancel_clr_one", lk_clr, 1'b0);

    // Three mismatching entries; lockout (when enabled) holds for LC cycles.
    mode_req = 1'b1;
    lk_res = 1'b0;
    @(negedge clk);
    for (int t = 0; t < 3; t++) begin
      type_digits(4'd2, 4'd4, 4'd6, 4'd8, 4'd0, 4'd1);
      enter_and_wait(lat, gu, gf);
      chk("fail_seen", gf, 1'b1);
      chk("fail_latency", lat, 3 + JW + 1);
    end
    cnt = lockout ? 1 : 0;
    for (int i = 0; i < LC + 20; i++) begin
      random_key();
      @(negedge clk);
      if (lockout) cnt++;
    end
    key_valid = 1'b0;
    chk("lockout_len", cnt, EXP_LOCK_LEN);
    press(4'hC);

    // Reset during WRITE2: everything back to reset values, no set_done.
    mode_req = 1'b0;
    @(negedge clk);
    type_digits(4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9);
    key_valid = 1'b1;
    key_code = 4'hA;
    @(posedge clk);
    #1 key_valid = 1'b0;
    @(posedge clk);
    #1 clr_n = 1'b0;
    #1;
    chk("rst_mid_sel", {lk_a1, lk_a0}, 2'b11);
    chk("rst_mid_a", lk_inA, 4'd0);
    chk("rst_mid_cnt", digit_cnt, 3'd0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (set_done) cnt++;
    end
    chk("rst_mid_no_set_done", cnt, 0);

    // Randomized traffic, including back-to-back strobes.
    for (int i = 0; i < 3000; i++) begin
      random_key();
      mode_req = 1'($urandom_range(0, 1));
      lk_res = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    key_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_entry_sequencer.md
Name: keypad_entry_sequencer

Overview:
- Front-end driver for the six-digit lock controller's pair-write/judge interface.
- Takes single key strokes (digits 0-9, ENTER, BACKSPACE, CANCEL) and buffers up to six digits.
- On ENTER, replays the buffer as three pair-writes, then, in entry mode, issues a judge select and samples the compare result.
- Produces unlock/fail pulses and a failed-attempt lockout toward the door actuator and status LEDs.

Parameters:
- MAX_FAIL, 3, consecutive failed entries before lockout (1..15).
- LOCKOUT_CYCLES, 1000, clk cycles spent in lockout (>=1).
- JUDGE_WAIT, 2, clk cycles between presenting judge select and sampling lk_res (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- clr_n  in  1  reset, asynchronous, active-low.
- key_valid  in  1  one-cycle strobe; key_code valid when high.
- key_code  in  4  0x0-0x9 digit, 0xA ENTER, 0xB BACKSPACE, 0xC CANCEL; 0xD-0xF ignored.
- mode_req  in  1  0 = set password, 1 = enter password; sampled only in IDLE with empty buffer.
- lk_res  in  1  compare result from the lock controller.
- lk_m  out  1  mode to the lock controller.
- lk_inA  out  4  first digit of the current pair.
- lk_inB  out  4  second digit of the current pair.
- lk_a0  out  1  position-select LSB.
- lk_a1  out  1  position-select MSB.
- lk_clr  out  1  one-cycle clear to the lock controller.
- digit_cnt  out  3  digits currently buffered (0..6).
- set_done  out  1  one-cycle pulse when a set-mode write completes.
- unlock  out  1  one-cycle pulse when lk_res=1.
- fail  out  1  one-cycle pulse when lk_res=0.
- lockout  out  1  high while in LOCKOUT.

Behaviour:
- Reset values: lk_m=0, lk_inA=lk_inB=0, {lk_a1,lk_a0}=11 (judge select; writes nothing), lk_clr=0, digit_cnt=0, all pulses 0, lockout=0, fail counter 0, state IDLE, buffer zeroed.
- Select encoding {lk_a1,lk_a0}: 00 = digits 1-2, 01 = digits 3-4, 10 = digits 5-6, 11 = judge/idle. The select is 11 in every state except WRITE1-3.
- States:
  - IDLE/COLLECT (one state distinguished by digit_cnt). Digit with digit_cnt<6: store at index digit_cnt, increment. Digit with digit_cnt=6: ignored. BACKSPACE: decrement if >0, else ignored. CANCEL: clear the buffer, digit_cnt=0, pulse lk_clr for 1 cycle; lk_m unchanged. ENTER with digit_cnt=6: go to WRITE1. ENTER with digit_cnt<6: ignored. lk_m <= mode_req each cycle while digit_cnt=0.
  - WRITE1, WRITE2, WRITE3: one cycle each. Drive select 00/01/10 with lk_inA/lk_inB = digits (1,2), (3,4), (5,6). After WRITE3: if lk_m=0, pulse set_done and go to IDLE; else go to JUDGE.
  - JUDGE: hold select 11 for JUDGE_WAIT cycles, then sample lk_res.
    - lk_res=1: pulse unlock, fail counter=0, go to IDLE.
    - lk_res=0: pulse fail, increment the counter (saturating); if counter reaches MAX_FAIL, go to LOCKOUT, else IDLE.
  - Every exit to IDLE clears the buffer and digit_cnt.
  - LOCKOUT: lockout=1; count LOCKOUT_CYCLES; on expiry, counter=0, lockout=0, go to IDLE.
- Keys are ignored outside IDLE/COLLECT, including CANCEL.
- Total ENTER-to-unlock latency in entry mode: 3 + JUDGE_WAIT + 1 cycles.
- key_valid on consecutive cycles: every strobe is processed.
- clr_n asserted mid-operation: immediate return to reset values; no partial pulse completes.

Optional Feature:
- FAIL_LOCKOUT_EN defined: fail counter and LOCKOUT state as above.
- FAIL_LOCKOUT_EN undefined: no counter, no LOCKOUT state; a failure returns to IDLE; lockout tied 0; MAX_FAIL and LOCKOUT_CYCLES unused.

Test Plan:
- Reset, mode_req=0, keys 1,2,3,4,5,6,ENTER -> one cycle each of select 00 (1,2), 01 (3,4), 10 (5,6); set_done pulses one cycle after WRITE3; digit_cnt returns to 0.
- mode_req=1, keys 1..6, ENTER, lk_res=1 -> unlock pulses exactly 3+JUDGE_WAIT+1 cycles after ENTER; fail stays 0.
- Keys 1,2,3, BACKSPACE, 9,4,5,6, ENTER -> pairs written are (1,2), (9,4), (5,6); seven digits typed -> the seventh is ignored, digit_cnt=6.
- ENTER with digit_cnt=4 -> no select change, state unchanged; CANCEL -> lk_clr high for one cycle, digit_cnt=0.
- FAIL_LOCKOUT_EN, three entries with lk_res=0 -> three fail pulses, lockout high for 1000 cycles, keys ignored throughout, then IDLE.
- clr_n low during WRITE2 -> select immediately 11, all outputs at reset values, no set_done.
